// File: rtl/control_sequencer_if.sv
// Control bundle between the mini-SRC control sequencer and its datapath.
// The sequencer owns every control strobe; the datapath supplies IR and the CON flag.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        con;

  // Bus source selects
  logic        PCout;
  logic        ZLowout;
  logic        MDRout;
  logic        Cout;

  // Register loads
  logic        MAR_enable;
  logic        Z_low_enable;
  logic        PC_enable;
  logic        MDR_enable;
  logic        IR_enable;
  logic        Y_enable;
  logic        IncPC;

  // Memory strobes
  logic        Read;
  logic        Write;

  // IR-field register select logic
  logic        GRA;
  logic        GRB;
  logic        GRC;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        CON_in;

  logic [4:0]  operation;
  logic        running;
  logic        illegal_op;

  modport master (
    input  ir, con,
    output PCout, ZLowout, MDRout, Cout,
    output MAR_enable, Z_low_enable, PC_enable, MDR_enable, IR_enable, Y_enable, IncPC,
    output Read, Write,
    output GRA, GRB, GRC, Rin, Rout, BAout, CON_in,
    output operation, running, illegal_op
  );

  modport slave (
    output ir, con,
    input  PCout, ZLowout, MDRout, Cout,
    input  MAR_enable, Z_low_enable, PC_enable, MDR_enable, IR_enable, Y_enable, IncPC,
    input  Read, Write,
    input  GRA, GRB, GRC, Rin, Rout, BAout, CON_in,
    input  operation, running, illegal_op
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer for the mini-SRC CPU: fetch, per-opcode execute T-states,
// back to fetch; halt parks the machine until clear.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [4:0]  OP_ADD   = 5'b00011
) (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  localparam logic [3:0] RESET = 4'd0;
  localparam logic [3:0] T0    = 4'd1;
  localparam logic [3:0] T1    = 4'd2;
  localparam logic [3:0] T2    = 4'd3;
  localparam logic [3:0] T2B   = 4'd4;
  localparam logic [3:0] T3    = 4'd5;
  localparam logic [3:0] T4    = 4'd6;
  localparam logic [3:0] T5    = 4'd7;
  localparam logic [3:0] T6    = 4'd8;
  localparam logic [3:0] T7    = 4'd9;
  localparam logic [3:0] T8    = 4'd10;
  localparam logic [3:0] HALT  = 4'd11;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  // ALU codes the immediate forms map onto (add / and / or)
  localparam logic [4:0] AluAdd = 5'b00011;
  localparam logic [4:0] AluAnd = 5'b00101;
  localparam logic [4:0] AluOr  = 5'b00110;

  localparam logic [1:0] WaitLoad = 2'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [1:0] wait_q, wait_d;

  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_rtype, is_imm, is_br, is_nop, is_halt, is_legal;
  logic [4:0] imm_op;
  logic       unused_ir;

  assign opcode    = bus.ir[31:27];
  assign unused_ir = ^bus.ir[26:0];

  // Opcode class decode
  always_comb begin
    is_ld    = (opcode == OpLd);
    is_ldi   = (opcode == OpLdi);
    is_st    = (opcode == OpSt);
    is_rtype = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    is_imm   = (opcode == OpAddi) || (opcode == OpAndi) || (opcode == OpOri);
    is_br    = (opcode == OpBr);
    is_nop   = (opcode == OpNop);
    is_halt  = (opcode == OpHalt);
    is_legal = is_ld | is_ldi | is_st | is_rtype | is_imm | is_br | is_nop | is_halt;
    imm_op   = AluAdd;
    if (opcode == OpAndi) imm_op = AluAnd;
    if (opcode == OpOri)  imm_op = AluOr;
  end

  // State and wait-counter registers; clear forces RESET immediately
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= RESET;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and wait-counter update
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RESET: state_d = T0;
      T0: begin
        state_d = T1;
        wait_d  = WaitLoad;
      end
      T1: begin
        if (wait_q == 2'd0) begin
          state_d = T2;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      T2:  state_d = T2B;
      T2B: state_d = T3;
      T3: begin
        if (is_halt) begin
          state_d = HALT;
        end else if (is_ld | is_ldi | is_st | is_rtype | is_imm | is_br) begin
          state_d = T4;
        end else begin
          state_d = T0; // nop and illegal opcodes
        end
      end
      T4: state_d = T5;
      T5: begin
        // Counter only matters for the ld memory read in T6
        wait_d  = WaitLoad;
        state_d = (is_ld | is_st | is_br) ? T6 : T0;
      end
      T6: begin
        if (is_ld) begin
          if (wait_q == 2'd0) begin
            state_d = T7;
          end else begin
            wait_d = wait_q - 2'd1;
          end
        end else if (is_st) begin
          state_d = T7;
        end else begin
          state_d = T0;
        end
      end
      T7:      state_d = is_ld ? T8 : T0;
      T8:      state_d = T0;
      HALT:    state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  // Moore output decode; con only matters in the branch T6 state
  always_comb begin
    bus.PCout        = 1'b0;
    bus.ZLowout      = 1'b0;
    bus.MDRout       = 1'b0;
    bus.Cout         = 1'b0;
    bus.MAR_enable   = 1'b0;
    bus.Z_low_enable = 1'b0;
    bus.PC_enable    = 1'b0;
    bus.MDR_enable   = 1'b0;
    bus.IR_enable    = 1'b0;
    bus.Y_enable     = 1'b0;
    bus.IncPC        = 1'b0;
    bus.Read         = 1'b0;
    bus.Write        = 1'b0;
    bus.GRA          = 1'b0;
    bus.GRB          = 1'b0;
    bus.GRC          = 1'b0;
    bus.Rin          = 1'b0;
    bus.Rout         = 1'b0;
    bus.BAout        = 1'b0;
    bus.CON_in       = 1'b0;
    bus.operation    = 5'b00000;
    bus.illegal_op   = 1'b0;
    bus.running      = (state_q != RESET) && (state_q != HALT);
    case (state_q)
      T0: begin
        bus.PCout      = 1'b1;
        bus.MAR_enable = 1'b1;
        bus.PC_enable  = 1'b1;
        bus.IncPC      = 1'b1;
      end
      T1: bus.Read = 1'b1;
      T2: begin
        bus.Read       = 1'b1;
        bus.MDR_enable = 1'b1;
      end
      T2B: begin
        bus.MDRout    = 1'b1;
        bus.IR_enable = 1'b1;
      end
      T3: begin
        if (is_ld | is_ldi | is_st) begin
          bus.GRB      = 1'b1;
          bus.BAout    = 1'b1;
          bus.Y_enable = 1'b1;
        end else if (is_rtype | is_imm) begin
          bus.GRB      = 1'b1;
          bus.Rout     = 1'b1;
          bus.Y_enable = 1'b1;
        end else if (is_br) begin
          bus.GRA    = 1'b1;
          bus.Rout   = 1'b1;
          bus.CON_in = 1'b1;
        end else if (!is_legal) begin
          bus.illegal_op = 1'b1;
        end
      end
      T4: begin
        if (is_ld | is_ldi | is_st) begin
          bus.Cout         = 1'b1;
          bus.operation    = OP_ADD;
          bus.Z_low_enable = 1'b1;
        end else if (is_rtype) begin
          bus.GRC          = 1'b1;
          bus.Rout         = 1'b1;
          bus.operation    = opcode;
          bus.Z_low_enable = 1'b1;
        end else if (is_imm) begin
          bus.Cout         = 1'b1;
          bus.operation    = imm_op;
          bus.Z_low_enable = 1'b1;
        end else if (is_br) begin
          bus.PCout    = 1'b1;
          bus.Y_enable = 1'b1;
        end
      end
      T5: begin
        if (is_ld | is_st) begin
          bus.ZLowout    = 1'b1;
          bus.MAR_enable = 1'b1;
        end else if (is_ldi | is_rtype | is_imm) begin
          bus.ZLowout = 1'b1;
          bus.GRA     = 1'b1;
          bus.Rin     = 1'b1;
        end else if (is_br) begin
          bus.Cout         = 1'b1;
          bus.operation    = OP_ADD;
          bus.Z_low_enable = 1'b1;
        end
      end
      T6: begin
        if (is_ld) begin
          bus.Read = 1'b1;
        end else if (is_st) begin
          // Read stays low so MDR loads from the bus, not memory
          bus.GRA        = 1'b1;
          bus.Rout       = 1'b1;
          bus.MDR_enable = 1'b1;
        end else if (is_br && bus.con) begin
          bus.ZLowout   = 1'b1;
          bus.PC_enable = 1'b1;
        end
      end
      T7: begin
        if (is_ld) begin
          bus.Read       = 1'b1;
          bus.MDR_enable = 1'b1;
        end else if (is_st) begin
          bus.Write = 1'b1;
        end
      end
      T8: begin
        bus.MDRout = 1'b1;
        bus.GRA    = 1'b1;
        bus.Rin    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
